rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 32, number of requesters and mux inputs.
REQ-002 Parameter: SEL_WIDTH, 5, selector width; SHALL equal clog2(NUM_REQ).
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_ni  input  1  asynchronous, active-low reset.
REQ-005 Port: req_i  input  NUM_REQ  per-requester level request; high means one or more items are pending.
REQ-006 Port: data_i  input  NUM_REQ  per-requester data bit, routed through the internal NUM_REQ:1 mux.
REQ-007 Port: sel_o  output  SEL_WIDTH  index of the current grant; drives the mux selector.
REQ-008 Port: out_valid_o  output  1  a granted item is presented.
REQ-009 Port: out_ready_i  input  1  consumer accepts the item.
REQ-010 Port: out_data_o  output  1  data_i[sel_o]; combinational from the registered sel_o.
REQ-011 Port: ack_o  output  NUM_REQ  one-hot pulse to requester sel_o on the handshake cycle; one item is consumed per pulse.
REQ-012 Port: lock_i  input  1  present only when MUX_ARB_LOCK_EN is defined (REQ-026).

Function
REQ-013 FSM states SHALL be IDLE (out_valid_o=0) and GRANT (out_valid_o=1).
REQ-014 IDLE with req_i==0 SHALL remain in IDLE.
REQ-015 IDLE with req_i!=0 SHALL register a winner into sel_o and enter GRANT on the next edge; latency from req_i to out_valid_o is 1 cycle.
REQ-016 Winner search SHALL start at (last+1) mod NUM_REQ and take the first set req_i bit in ascending order with wrap-around; last is the most recent served index, and it is checked last.
REQ-017 In GRANT, sel_o SHALL be held stable until out_valid_o && out_ready_i; no revocation if req_i[sel_o] drops.
REQ-018 Handshake cycle: ack_o SHALL equal 1<<sel_o, last<=sel_o; ack_o SHALL be 0 in every other cycle.
REQ-019 On handshake with any req_i bit set, the FSM SHALL stay in GRANT with the new winner per REQ-016, computed from req_i in the handshake cycle (back-to-back, no bubble); otherwise it SHALL go to IDLE.
REQ-020 A requester still high after its ack SHALL be treated as having another item; it wins again only if no other request is pending.
REQ-021 out_valid_o SHALL NOT depend combinationally on out_ready_i.
REQ-022 sel_o values >= NUM_REQ SHALL never be produced.

Reset
REQ-023 Asserting rst_ni low SHALL immediately force IDLE, sel_o=0, last=NUM_REQ-1, out_valid_o=0, ack_o=0, including mid-GRANT; an in-flight item is dropped without ack.
REQ-024 After rst_ni deasserts, the first grant SHALL search from index 0.
REQ-025 out_data_o SHALL follow data_i[0] while in reset.

Configuration
REQ-026 Macro MUX_ARB_LOCK_EN: when defined, if lock_i=1 in a handshake cycle and req_i[sel_o]=1, the next grant SHALL be the same sel_o (rotation suspended); if req_i[sel_o]=0, arbitration SHALL follow REQ-016.
REQ-027 Without MUX_ARB_LOCK_EN, the lock_i port and its logic SHALL be absent, and arbitration SHALL always follow REQ-016.

Verification
REQ-028 After reset, req_i=0x0000_0005, out_ready_i=1 -> sel_o=0 (valid at cycle 1), then sel_o=2, then sel_o=0, with an ack_o pulse on each cycle.
REQ-029 req_i=0x8000_0001 after last=31 -> grant 0, then 31; the wrap-around order is verified.
REQ-030 Single requester 7 with out_ready_i=0 for 5 cycles -> sel_o=7, out_valid_o=1 held, ack_o=0; out_ready_i=1 -> ack_o=0x80 for exactly one cycle.
REQ-031 Granted requester with data_i[sel_o] toggling -> out_data_o tracks data_i[sel_o] in the same cycle; the other data_i bits have no effect.
REQ-032 rst_ni low mid-GRANT (sel_o=9) -> out_valid_o=0 and sel_o=0 asynchronously, no ack_o; after release, req_i=0x200 -> sel_o=9.
REQ-033 MUX_ARB_LOCK_EN defined, req_i=0x0000_0003, lock_i=1 -> requester 0 granted repeatedly; lock_i=0 -> next grant is 1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a NUM_REQ:1 data mux with a valid/ready output handshake.
// Optional MUX_ARB_LOCK_EN adds lock_i, which holds the current grant across handshakes.
module rr_mux_arbiter #(
    parameter int NUM_REQ   = 32,
    parameter int SEL_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   data_i,
`ifdef MUX_ARB_LOCK_EN
    input  logic                 lock_i,
`endif
    input  logic                 out_ready_i,
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic                 out_valid_o,
    output logic                 out_data_o,
    output logic [NUM_REQ-1:0]   ack_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] last_q, last_d;
    logic                 hs;

    // First set request strictly after 'last', wrapping; 'last' itself is visited last.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [NUM_REQ-1:0]   req,
        input logic [SEL_WIDTH-1:0] last
    );
        logic [SEL_WIDTH-1:0] win;
        logic                 found;
        int                   idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                win   = SEL_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign hs = (state_q == GRANT) && out_ready_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    sel_d   = rr_pick(req_i, last_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    last_d = sel_q;
                    if (|req_i) begin
                        // Next winner is taken in the handshake cycle so grants run back-to-back.
                        sel_d = rr_pick(req_i, sel_q);
`ifdef MUX_ARB_LOCK_EN
                        if (lock_i && req_i[sel_q]) sel_d = sel_q;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign sel_o       = sel_q;
    assign out_valid_o = (state_q == GRANT);
    assign out_data_o  = data_i[sel_q];
    assign ack_o       = hs ? (NUM_REQ'(1) << sel_q) : '0;

endmodule
